// File: rtl/noc_pkg.sv
// Shared NoC router types: port and flit-type encodings,
// flit field positions and route FSM states.
package noc_pkg;

  typedef enum logic [2:0] {
    PORT_NONE  = 3'b000,
    PORT_NORTH = 3'b001,
    PORT_SOUTH = 3'b010,
    PORT_EAST  = 3'b011,
    PORT_WEST  = 3'b100,
    PORT_LOCAL = 3'b101
  } port_e;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  localparam int TYPE_W  = 2;
  localparam int COORD_W = 2;
  localparam int DX_LSB  = 2;
  localparam int DY_LSB  = 0;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational XY dimension-order port selection
// with destination range check against the mesh size.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int MESH_X = 4,
  parameter int MESH_Y = 4
) (
  input  logic [COORD_W-1:0] dest_x_i,
  input  logic [COORD_W-1:0] dest_y_i,
  input  logic [COORD_W-1:0] cur_x_i,
  input  logic [COORD_W-1:0] cur_y_i,
  output port_e              port_o,
  output logic               range_err_o
);

  // A mesh of 4 or more columns/rows covers every 2-bit coordinate.
  localparam bit X_LIM = MESH_X < 4;
  localparam bit Y_LIM = MESH_Y < 4;
  localparam logic [COORD_W-1:0] X_MAX =
    X_LIM ? COORD_W'(MESH_X) : '1;
  localparam logic [COORD_W-1:0] Y_MAX =
    Y_LIM ? COORD_W'(MESH_Y) : '1;

  // X first, then Y, then deliver locally.
  always_comb begin
    port_o = PORT_LOCAL;
    if (dest_x_i > cur_x_i)
      port_o = PORT_EAST;
    else if (dest_x_i < cur_x_i)
      port_o = PORT_WEST;
    else if (dest_y_i > cur_y_i)
      port_o = PORT_NORTH;
    else if (dest_y_i < cur_y_i)
      port_o = PORT_SOUTH;
  end

  // Flag destinations outside the mesh.
  always_comb begin
    range_err_o = (X_LIM && (dest_x_i >= X_MAX)) ||
                  (Y_LIM && (dest_y_i >= Y_MAX));
  end

endmodule

// File: rtl/route_compute.sv
// Wormhole route computation: routes a packet head once,
// holds the port lock until the tail is popped.
module route_compute
  import noc_pkg::*;
#(
  parameter int X_ADDR = 0,
  parameter int Y_ADDR = 0,
  parameter int MESH_X = 4,
  parameter int MESH_Y = 4,
  parameter int FLIT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ib_empty_i,
  input  logic [FLIT_W-1:0] ib_flit_i,
  input  logic              flit_pop_i,
  output logic [2:0]        nhr_address_o,
  output logic              nhr_write_o,
  output logic              route_busy_o,
  output logic              route_error_o,
  output logic [7:0]        pkt_cnt_o
);

  localparam logic [COORD_W-1:0] CUR_X = COORD_W'(X_ADDR);
  localparam logic [COORD_W-1:0] CUR_Y = COORD_W'(Y_ADDR);

  state_e      state_q, state_d;
  logic [2:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  flit_type_e  ftype;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  port_e       port;
  logic        range_err;
  logic        unused_flit;

  assign ftype  = flit_type_e'(ib_flit_i[FLIT_W-1 -: TYPE_W]);
  assign dest_x = ib_flit_i[DX_LSB +: COORD_W];
  assign dest_y = ib_flit_i[DY_LSB +: COORD_W];
  assign unused_flit = ^ib_flit_i;

  xy_route_calc #(
    .MESH_X (MESH_X),
    .MESH_Y (MESH_Y)
  ) u_xy (
    .dest_x_i    (dest_x),
    .dest_y_i    (dest_y),
    .cur_x_i     (CUR_X),
    .cur_y_i     (CUR_Y),
    .port_o      (port),
    .range_err_o (range_err)
  );

  // Next-state: route heads in IDLE, release lock on tail pop.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!ib_empty_i) begin
          if ((ftype == FLIT_HEAD || ftype == FLIT_SINGLE) &&
              !range_err) begin
            addr_d  = port;
            write_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!ib_empty_i && flit_pop_i &&
            (ftype == FLIT_TAIL || ftype == FLIT_SINGLE)) begin
          state_d = ST_IDLE;
          addr_d  = PORT_NONE;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= PORT_NONE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nhr_address_o = addr_q;
  assign nhr_write_o   = write_q;
  assign route_busy_o  = (state_q == ST_HOLD);
  assign route_error_o = err_q;
  assign pkt_cnt_o     = cnt_q;

endmodule

// File: doc/route_compute.md
ROUTE_COMPUTE -- requirements
Module: route_compute

Interface
REQ-001 SHALL have parameters: X_ADDR, default 0, router x-coordinate; Y_ADDR, default 0, router y-coordinate; MESH_X, default 4, mesh columns; MESH_Y, default 4, mesh rows; FLIT_W, default 32, flit width.
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-low:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- ib_empty_i  input  1  input buffer empty
- ib_flit_i  input  FLIT_W  flit at input-buffer head, valid when ib_empty_i=0
- flit_pop_i  input  1  head flit consumed this cycle by crossbar
- nhr_address_o  output  3  computed next-hop port, to next-hop register nhr_address_i
- nhr_write_o  output  1  one-cycle write strobe, to next-hop register nhr_write_i
- route_busy_o  output  1  packet route held (wormhole lock)
- route_error_o  output  1  sticky error flag
- pkt_cnt_o  output  8  packets completed, wraps

Function
REQ-003 Flit type SHALL be ib_flit_i[FLIT_W-1:FLIT_W-2]: 00 body, 01 head, 10 tail, 11 single (head+tail).
REQ-004 Head/single flits SHALL carry dest_x in [3:2] and dest_y in [1:0].
REQ-005 Port encoding SHALL be: 000 NONE, 001 NORTH, 010 SOUTH, 011 EAST, 100 WEST, 101 LOCAL; 110/111 never driven.
REQ-006 Routing SHALL be XY: dest_x>X_ADDR EAST; dest_x<X_ADDR WEST; else dest_y>Y_ADDR NORTH; dest_y<Y_ADDR SOUTH; else LOCAL.
REQ-007 FSM SHALL have states IDLE, HOLD.
REQ-008 In IDLE with ib_empty_i=0 and head/single flit at head, with dest in range, SHALL register the port into nhr_address_o, pulse nhr_write_o for exactly one cycle on the next clock edge, and enter HOLD (latency 1 cycle).
REQ-009 In IDLE with ib_empty_i=0 and body/tail flit at head, SHALL set route_error_o, leave nhr_write_o low, and stay in IDLE.
REQ-010 In IDLE with dest_x>=MESH_X or dest_y>=MESH_Y, SHALL set route_error_o, leave nhr_write_o low, and stay in IDLE.
REQ-011 In HOLD, SHALL keep nhr_address_o stable, hold nhr_write_o low, and hold route_busy_o=1.
REQ-012 In HOLD, ib_empty_i=1 SHALL not change state (wormhole stall).
REQ-013 In HOLD, flit_pop_i=1 with a tail/single flit at head SHALL return the FSM to IDLE and increment pkt_cnt_o by 1 (255->0).
REQ-014 flit_pop_i in IDLE SHALL be ignored.
REQ-015 flit_pop_i while ib_empty_i=1 SHALL be ignored.
REQ-016 If a tail pop and a new head coincide, the new head SHALL be routed on the cycle after IDLE is re-entered; there is no same-cycle bypass.
REQ-017 nhr_address_o SHALL return to 000 on entry to IDLE.
REQ-018 route_error_o SHALL clear only on reset.

Reset
REQ-019 On reset=0, asynchronously: state IDLE, nhr_address_o=000, nhr_write_o=0, route_busy_o=0, route_error_o=0, pkt_cnt_o=0.
REQ-020 Reset asserted mid-packet SHALL abandon the lock; the first head after release is routed normally.

Structure
REQ-021 Package noc_pkg SHALL hold the port enum, flit-type enum, flit field positions, and FSM state typedef.
REQ-022 XY decision SHALL be a combinational sub-module xy_route_calc (dest, X_ADDR/Y_ADDR in; port and range error out), instantiated once.

Verification
REQ-023 X_ADDR=1,Y_ADDR=1, head dest(3,1) -> one cycle later nhr_address_o=011, nhr_write_o=1 one cycle, route_busy_o=1.
REQ-024 Head dest(1,0), 2 body flits with stalls (ib_empty_i toggling), tail popped -> nhr_address_o=010 held throughout; IDLE after tail pop; pkt_cnt_o=1.
REQ-025 Single flit dest(1,1) popped while next head dest(0,1) present -> 101 write, IDLE, then 100 write one cycle after IDLE entry.
REQ-026 Body flit at head in IDLE, then head dest(3,3) with MESH_X=3 -> route_error_o=1 both times, no nhr_write_o; stays set until reset.
REQ-027 reset=0 in HOLD mid-packet -> all outputs zero immediately; after release, head dest(2,1) -> 011 written after 1 cycle.
REQ-028 256 single-flit packets -> pkt_cnt_o wraps to 0.
